// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART link (receiver and transmitter).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OS_RATE   = 16;
    localparam int DATA_BITS = 8;

    // s_cnt values at which the line is sampled: mid start bit, then mid data/stop bit
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-cycle pulse every os_div clocks.
module uart_os_tick #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int OS_RATE   = 16
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int OS_DIV = clk_freq / (baud_rate * OS_RATE);
    localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    generate
        if (OS_DIV < 1) begin : g_bad_div
            $error("uart_os_tick: clk_freq too low for baud_rate * OS_RATE");
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the terminal count, wrapping the counter back to zero
    always_comb begin
        os_tick = (cnt_q == LAST);
        cnt_d   = os_tick ? '0 : cnt_q + 1'b1;
    end

    // Divider counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_line,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);

    logic os_tick;

    uart_os_tick #(
        .clk_freq (clk_freq),
        .baud_rate(baud_rate),
        .OS_RATE  (OS_RATE)
    ) u_os_tick (
        .clk    (clk),
        .reset  (reset),
        .os_tick(os_tick)
    );

    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic fall;

    // Two-stage synchronizer plus history stage for edge detection; idle-high reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_line;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign fall = rx_s3_q & ~rx_s2_q;

    uart_state_e          state_q, state_d;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [2:0]           b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 busy_q, busy_d;

    // Frame FSM next-state: counters, shift register and registered outputs
    always_comb begin
        state_d       = state_q;
        s_cnt_d       = s_cnt_q;
        b_cnt_d       = b_cnt_q;
        shreg_d       = shreg_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        framing_err_d = 1'b0;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (fall) begin
                    s_cnt_d = '0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (os_tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == MID_START) begin
                        if (!rx_s2_q) begin
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                            state_d = DATA;
                        end else begin
                            // Line back high at mid start bit: treat as glitch
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            DATA: begin
                if (os_tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == MID_BIT) begin
                        shreg_d = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
                        if (b_cnt_q == 3'(DATA_BITS - 1)) state_d = STOP;
                        else                              b_cnt_d = b_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (os_tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == MID_BIT) begin
                        if (rx_s2_q) begin
                            data_out_d   = shreg_q;
                            data_valid_d = 1'b1;
                        end else begin
                            framing_err_d = 1'b1;
                        end
                        // Leave at mid-stop so an immediately following start edge is caught
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            s_cnt_q       <= '0;
            b_cnt_q       <= '0;
            shreg_q       <= '0;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_cnt_q       <= s_cnt_d;
            b_cnt_q       <= b_cnt_d;
            shreg_q       <= shreg_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames vs a frame-level model.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int PER      = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    uart_rx #(
        .clk_freq (CLK_FREQ),
        .baud_rate(BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_line    (rx_line),
        .data_out   (data_out),
        .data_valid (data_valid),
        .framing_err(framing_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed output events {kind, data_out}: kind 1 = data_valid, 0 = framing_err
    logic [8:0] obs_q[$];
    int         busy_cnt = 0;
    int         excl_viol = 0;
    int         stray_upd = 0;
    logic [7:0] dout_prev = 8'h00;
    logic       rst_prev = 1'b0;

    always @(negedge clk) begin
        if (data_valid)  obs_q.push_back({1'b1, data_out});
        if (framing_err) obs_q.push_back({1'b0, data_out});
        if (data_valid && framing_err) excl_viol <= excl_viol + 1;
        if (reset && rst_prev && (data_out !== dout_prev) && !data_valid) stray_upd <= stray_upd + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        dout_prev <= data_out;
        rst_prev  <= reset;
    end

    // Frame-level reference model: expected events and last good byte
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         rd_idx = 0;

    task automatic drive(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
        drive(1'b0, per);
        for (int i = 0; i < 8; i++) drive(d[i], per);
        drive(stop, per);
        if (stop) begin
            exp_q.push_back({1'b1, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b0, last_good});
        end
    endtask

    task automatic check_events(input string tag);
        int t;
        int n_obs;
        t = 0;
        while ((obs_q.size() < rd_idx + exp_q.size()) && (t < 4000)) begin
            @(posedge clk);
            t++;
        end
        repeat (20) @(posedge clk);
        #2;
        n_obs = obs_q.size() - rd_idx;
        chk({tag, "_count"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_obs) chk({tag, "_event"}, {23'b0, obs_q[rd_idx + i]}, {23'b0, exp_q[i]});
        end
        rd_idx = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        int b0;
        int len;
        logic [7:0] d;
        logic       stop;
        int         per;
        int         idle;

        // Reset state
        repeat (5) @(posedge clk);
        #2;
        chk("rst_dout",  {24'b0, data_out}, 32'h00);
        chk("rst_dv",    {31'b0, data_valid}, 0);
        chk("rst_fe",    {31'b0, framing_err}, 0);
        chk("rst_busy",  {31'b0, busy}, 0);
        reset = 1'b1;
        drive(1'b1, 100);

        // Single good frame, busy window about 9.5 bits
        b0 = busy_cnt;
        send_frame(8'hA5, 1'b1, PER);
        drive(1'b1, PER);
        len = busy_cnt - b0;
        chk("a5_busy_len", {31'b0, (len >= 1500 && len <= 1530)}, 1);
        check_events("a5");
        chk("a5_dout", {24'b0, data_out}, 32'hA5);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, PER);
        send_frame(8'hFF, 1'b1, PER);
        drive(1'b1, PER);
        check_events("b2b");

        // Short low pulse is rejected at mid start bit
        b0 = busy_cnt;
        drive(1'b0, 40);
        drive(1'b1, 300);
        len = busy_cnt - b0;
        chk("glitch_busy_len", {31'b0, (len > 60 && len < 120)}, 1);
        chk("glitch_busy_end", {31'b0, busy}, 0);
        check_events("glitch");

        // Framing error followed by break, then a good frame
        send_frame(8'h3C, 1'b0, PER);
        drive(1'b0, 2 * PER);
        drive(1'b1, PER);
        send_frame(8'h81, 1'b1, PER);
        drive(1'b1, PER);
        check_events("ferr");
        chk("ferr_dout", {24'b0, data_out}, 32'h81);

        // Reset mid-DATA of 0x5A, then a good frame
        drive(1'b0, PER);
        drive(1'b0, PER);
        drive(1'b1, PER);
        drive(1'b0, PER / 2);
        reset = 1'b0;
        #1;
        chk("mrst_dout", {24'b0, data_out}, 32'h00);
        chk("mrst_dv",   {31'b0, data_valid}, 0);
        chk("mrst_fe",   {31'b0, framing_err}, 0);
        chk("mrst_busy", {31'b0, busy}, 0);
        rx_line = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        reset = 1'b1;
        last_good = 8'h00;
        drive(1'b1, 200);
        send_frame(8'h12, 1'b1, PER);
        drive(1'b1, PER);
        check_events("mrst");
        chk("mrst_dout2", {24'b0, data_out}, 32'h12);

        // Baud mismatch of about +/-2%
        send_frame(8'hC3, 1'b1, 157);
        drive(1'b1, PER);
        send_frame(8'hC3, 1'b1, 163);
        drive(1'b1, PER);
        check_events("ppm");

        // Randomized frames: data, bit period, stop-bit errors and idle gaps
        for (int k = 0; k < 14; k++) begin
            d    = 8'($urandom);
            per  = $urandom_range(157, 163);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop, per);
            idle = stop ? ($urandom_range(0, 2) * per / 2) : (per + $urandom_range(0, per));
            if (idle > 0) drive(1'b1, idle);
        end
        drive(1'b1, PER);
        check_events("rand");

        chk("excl_viol", excl_viol, 0);
        chk("stray_dout", stray_upd, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive end of the team's 8N1 UART link, the counterpart of the transmitter. It samples the idle-high `rx_line` at 16x the baud rate and validates the start bit at mid-bit. It shifts in 8 data bits LSB-first and checks the stop bit. Each frame produces either a one-cycle `data_valid` pulse or a one-cycle `framing_err` pulse. It sits between the pad and the consuming logic (command decoder / FIFO).

## Interface
- `clk_freq`, default 1000000: system clock frequency in Hz.
- `baud_rate`, default 9600: line bit rate.
- Derived: `os_div = clk_freq / (baud_rate*16)`, using integer truncation. Elaboration fails if `os_div < 1`.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset. All state clears immediately while it is low.
- `rx_line` in 1: serial input. Asynchronous to `clk`. Idle level is 1.
- `data_out` out 8: last correctly framed byte. Holds its value until the next good frame.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `framing_err` out 1: one-cycle pulse when the stop bit samples as 0.
- `busy` out 1: high from start-bit detection until return to IDLE.

## Operation
- Input path: a 2-FF synchronizer (`rx_s1`, `rx_s2`) plus a history FF (`rx_s3`). All reset to 1.
- Falling edge is defined as `rx_s3==1 && rx_s2==0`.
- Oversample tick: free-running counter `0..os_div-1`. `os_tick` pulses for one cycle at wrap. Reset clears the counter to 0.
- Sample counter `s_cnt` is 4 bits, counts `os_tick`s, and wraps 15→0.
- Bit counter `b_cnt` is 3 bits.
- Shift register is 8 bits. It shifts right, and `rx_s2` enters at bit 7.
- States: IDLE, START, DATA, STOP (2-bit encoding, IDLE=0).
- IDLE: `busy`=0. On falling edge: `s_cnt`←0, `busy`←1, go to START.
- START: when `os_tick` and `s_cnt==7` (mid start bit):
  - If `rx_s2==0`: `s_cnt`←0, `b_cnt`←0, go to DATA.
  - Else it is a glitch: go to IDLE, `busy`←0, no output pulse.
- DATA: when `os_tick` and `s_cnt==15` (mid data bit): shift in `rx_s2`.
  - If `b_cnt==7`, go to STOP.
  - Else `b_cnt`+1.
- STOP: when `os_tick` and `s_cnt==15` (mid stop bit):
  - If `rx_s2==1`: `data_out`←shift register, `data_valid`←1.
  - Else: `framing_err`←1, and `data_out` is unchanged.
  - Either way: go to IDLE, `busy`←0.
- A new start is recognized only on a falling edge. A line held low after a framing error (break) produces no further frames until the line returns high and falls again.
- `data_valid` and `framing_err` are never high in the same cycle. Each is low in every other cycle.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `framing_err`=0, `busy`=0. State is IDLE and all counters are 0.
- Detection latency: 2–3 `clk` from the `rx_line` fall until `busy` rises (synchronizer plus edge register).
- Start validation occurs 8 `os_tick`s after detection. Each data sample is then spaced 16 `os_tick`s apart.
- Output latency: `data_valid`/`framing_err` asserts about 9.5 bit periods after the start edge. Tolerance is ±1 `os_tick` due to the free-running tick phase.
- `data_out` and `data_valid` update on the same edge. `data_out` is stable from that edge onward.
- There is no backpressure: a consumer must capture `data_out` within 10 bit periods.
- Back-to-back frames: the block returns to IDLE at mid-stop, so a start edge immediately following the stop bit is accepted.
- Reset mid-frame: outputs and state clear asynchronously, with no pulse. After release, the block waits for the line to be high followed by a falling edge, so a partial frame in progress is ignored until its next 1→0 transition.
- Clock-rate tolerance: frames must be received correctly with a ±2% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants IDLE/START/DATA/STOP.
  - `OS_RATE`=16.
  - `DATA_BITS`=8.
  - Mid-bit sample constants 7 and 15.
  - These are also used by the transmitter.
- One sub-module: `uart_os_tick`. It is parameterized by `clk_freq`, `baud_rate`, and `OS_RATE`, outputs `os_tick`, and uses the same asynchronous active-low reset.
- The synchronizer and FSM live in `uart_rx`.

## Test plan
Use `clk_freq`=1600000 and `baud_rate`=10000, giving `os_div`=10 and 160 clk per bit.
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) → one `data_valid` pulse, `data_out`=8'hA5, `framing_err` stays 0, `busy` high for about 1520 clk.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `data_valid` pulses, in order 8'h00 then 8'hFF.
- Line low for 40 clk then high → `busy` pulses and returns to 0 with no `data_valid` and no `framing_err` (glitch rejection).
- Frame 0x3C with stop bit = 0, line held low 2 bit times, then a valid 0x81 → one `framing_err` pulse with `data_out` unchanged, then one `data_valid` pulse with `data_out`=8'h81.
- `reset` asserted low mid-DATA of 0x5A, then released while the line is high, then a valid 0x12 → all outputs 0 immediately, no pulse for 0x5A, then `data_out`=8'h12.
- Frame 0xC3 transmitted at a bit period of 157 clk and again at 163 clk (±2%) → `data_out`=8'hC3 both times, no `framing_err`.
